// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, default MDU latencies and stage-control bundle indices
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;
  localparam int EN_PC  = 0;
  localparam int EN_FD  = 1;
  localparam int EN_DE  = 2;
  localparam int EN_EM  = 3;
  localparam int EN_MW  = 4;
  localparam int CLR_FD = 0;
  localparam int CLR_DE = 1;
  localparam int CLR_EM = 2;
  localparam int CLR_MW = 3;
endpackage

// File: rtl/pipe_seq_ctrl_mdu_timer.sv
// mdu_timer: loads N-2 for an MDU op, counts down on enable, freezes on hold, flags zero
module mdu_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  input  logic       i_hold,
  output logic       o_zero
);
  logic [7:0] r_cnt;
  // count register: load wins, hold overrides decrement, never wraps below zero
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && !i_hold && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
  end
  assign o_zero = r_cnt == 8'd0;
endmodule

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl: 5-stage pipeline sequencer (stall/flush/MDU wait/halt); PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic             in_LOADUSE,
  input  logic             in_BRANCH,
  input  logic             in_MDU_START,
  input  logic             in_MDU_DIV,
  input  logic             in_HALT,
  input  logic             in_GO,
  output logic             out_PC_EN,
  output logic             out_FD_EN,
  output logic             out_DE_EN,
  output logic             out_EM_EN,
  output logic             out_MW_EN,
  output logic             out_FD_CLR,
  output logic             out_DE_CLR,
  output logic             out_EM_CLR,
  output logic             out_MW_CLR,
  output logic             out_MDU_BUSY,
  output logic             out_MDU_DONE,
  output logic             out_HALTED,
  output logic [CNT_W-1:0] out_STALL_CNT,
  output logic [CNT_W-1:0] out_FLUSH_CNT
);
  state_t     r_state, w_next;
  logic       r_ret, w_ret;
  logic [4:0] w_en;
  logic [3:0] w_clr;
  logic       w_busy, w_done, w_halted, w_load, w_dec, w_hold, w_zero;
  logic [7:0] w_load_val;
  assign w_load_val = in_MDU_DIV ? 8'(DIV_CYC - 2) : 8'(MULT_CYC - 2);
  mdu_timer u_timer (
    .clk       (in_CLK),
    .rst       (in_RST),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_dec     (w_dec),
    .i_hold    (w_hold),
    .o_zero    (w_zero)
  );
  // state and return-target registers; r_ret=1 resumes into MDU_WAIT after halt
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_state <= ST_RUN;
      r_ret   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ret   <= w_ret;
    end
  end
  // next state and stage controls; MDU stall freezes IF/ID/EX and bubbles EX/MEM
  always_comb begin
    w_next   = r_state;
    w_ret    = r_ret;
    w_en     = '1;
    w_clr    = '0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_halted = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_hold   = 1'b0;
    if (in_RST) begin
      w_clr  = '1;
      w_next = ST_RUN;
      w_ret  = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (in_HALT) begin
            w_en   = '0;
            w_ret  = 1'b0;
            w_next = ST_HALT;
          end else if (in_MDU_START) begin
            w_en[EN_PC]   = 1'b0;
            w_en[EN_FD]   = 1'b0;
            w_en[EN_DE]   = 1'b0;
            w_clr[CLR_EM] = 1'b1;
            w_busy        = 1'b1;
            w_load        = 1'b1;
            w_next        = ST_MDU_WAIT;
          end else if (in_BRANCH) begin
            w_clr[CLR_FD] = 1'b1;
            w_clr[CLR_DE] = 1'b1;
          end else if (in_LOADUSE) begin
            w_en[EN_PC]   = 1'b0;
            w_en[EN_FD]   = 1'b0;
            w_clr[CLR_DE] = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (in_HALT) begin
            w_en   = '0;
            w_hold = 1'b1;
            w_ret  = 1'b1;
            w_next = ST_HALT;
          end else if (!w_zero) begin
            w_en[EN_PC]   = 1'b0;
            w_en[EN_FD]   = 1'b0;
            w_en[EN_DE]   = 1'b0;
            w_clr[CLR_EM] = 1'b1;
            w_busy        = 1'b1;
            w_dec         = 1'b1;
          end else begin
            w_done = 1'b1;
            w_next = ST_RUN;
          end
        end
        ST_HALT: begin
          w_en     = '0;
          w_hold   = 1'b1;
          w_halted = 1'b1;
          w_next   = in_GO ? (r_ret ? ST_MDU_WAIT : ST_RUN) : ST_HALT;
        end
        default: w_next = ST_RUN;
      endcase
    end
  end
  assign out_PC_EN    = w_en[EN_PC];
  assign out_FD_EN    = w_en[EN_FD];
  assign out_DE_EN    = w_en[EN_DE];
  assign out_EM_EN    = w_en[EN_EM];
  assign out_MW_EN    = w_en[EN_MW];
  assign out_FD_CLR   = w_clr[CLR_FD];
  assign out_DE_CLR   = w_clr[CLR_DE];
  assign out_EM_CLR   = w_clr[CLR_EM];
  assign out_MW_CLR   = w_clr[CLR_MW];
  assign out_MDU_BUSY = w_busy;
  assign out_MDU_DONE = w_done;
  assign out_HALTED   = w_halted;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_stall, w_flush;
  assign w_stall = !in_RST && !w_en[EN_PC] && r_state != ST_HALT;
  assign w_flush = !in_RST && r_state == ST_RUN && !in_HALT && !in_MDU_START && in_BRANCH;
  // saturating stall and branch-flush event counters
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
  assign out_STALL_CNT = r_stall_cnt;
  assign out_FLUSH_CNT = r_flush_cnt;
`else
  assign out_STALL_CNT = '0;
  assign out_FLUSH_CNT = '0;
`endif
endmodule
